// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM sequencing the shared multi-cycle RV32I datapath
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       ALU_op,
  output logic             reg_write,
  output logic             illegal_instr,
  output logic             bus_error,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
    EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10, TRAP = 4'd15
  } state_t;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, next;
  logic [WW-1:0] wait_cnt;
  logic waiting, timeout, retire, pc_w, ir_w, mem_w, reg_w;
  assign waiting = (state == FETCH || state == MEMREAD || state == MEMWRITE) && !mem_ready;
  assign timeout = waiting && wait_cnt == WW'(TIMEOUT_CYCLES - 1);
  assign pc_write = pc_w && !rst;
  assign ir_write = ir_w && !rst;
  assign mem_write = mem_w && !rst;
  assign reg_write = reg_w && !rst;
  assign state_dbg = state;
  // next-state and Moore/strobe decode; timeout overrides any transition and strobe
  always_comb begin
    next = state;
    pc_w = 1'b0;
    ir_w = 1'b0;
    mem_w = 1'b0;
    reg_w = 1'b0;
    retire = 1'b0;
    adr_src = 1'b0;
    result_src = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    ALU_op = 2'b00;
    case (state)
      FETCH: begin
        alu_src_b = 2'b10;
        result_src = 2'b10;
        ir_w = mem_ready;
        pc_w = mem_ready;
        next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          7'b0000011, 7'b0100011: next = MEMADR;
          7'b0110011: next = EXECR;
          7'b0010011: next = EXECI;
          7'b1100011: next = BEQ;
          7'b1101111: next = JAL;
          default: next = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        next = opcode == 7'b0000011 ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        next = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_w = 1'b1;
        retire = 1'b1;
        next = FETCH;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w = !timeout;
        retire = mem_ready;
        next = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        ALU_op = 2'b10;
        next = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        ALU_op = 2'b10;
        next = ALUWB;
      end
      ALUWB: begin
        reg_w = 1'b1;
        retire = 1'b1;
        next = FETCH;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        ALU_op = 2'b01;
        pc_w = zero;
        retire = 1'b1;
        next = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_w = 1'b1;
        next = ALUWB;
      end
      default: next = TRAP;
    endcase
    if (timeout) next = TRAP;
  end
  // state, wait counter, retire counter and sticky trap causes
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      wait_cnt <= '0;
      retired <= '0;
      illegal_instr <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state <= next;
      wait_cnt <= next != state ? '0 : waiting ? wait_cnt + 1'b1 : wait_cnt;
      retired <= retired + CNT_W'(retire);
      if (state == DECODE && next == TRAP) illegal_instr <= 1'b1;
      if (timeout) bus_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven and hand-sequenced checks of the control FSM
module tb_multicycle_ctrl;
  localparam int CW = 4;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;
  localparam logic [4:0] FS = 5'b10100, ADR = 5'b01000, MW = 5'b01010, RW = 5'b00001, PC = 5'b10000;
  typedef struct {
    logic rst;
    logic [6:0] op;
    logic z;
    logic mr;
    logic [3:0] st;
    logic [4:0] stb;
    logic [1:0] fl;
    logic [CW-1:0] ret;
  } vec_t;
  logic clk = 1'b0;
  logic rst, zero, mem_ready;
  logic [6:0] opcode;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr, bus_error;
  logic [1:0] result_src, alu_src_a, alu_src_b, ALU_op;
  logic [CW-1:0] retired;
  logic [3:0] state_dbg;
  vec_t tbl[$];
  vec_t sb[$];
  int compared = 0;
  int mismatched = 0;
  int row = 0;
  always #5 clk = ~clk;
  multicycle_ctrl #(.TIMEOUT_CYCLES(15), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALU_op(ALU_op),
    .reg_write(reg_write), .illegal_instr(illegal_instr), .bus_error(bus_error),
    .retired(retired), .state_dbg(state_dbg)
  );
  function automatic vec_t v(logic r, logic [6:0] o, logic z, logic m, logic [3:0] s,
                             logic [4:0] b, logic [1:0] f, logic [CW-1:0] n);
    vec_t x;
    x.rst = r; x.op = o; x.z = z; x.mr = m; x.st = s; x.stb = b; x.fl = f; x.ret = n;
    return x;
  endfunction
  // {result_src, alu_src_a, alu_src_b, ALU_op} required in each state
  function automatic logic [7:0] sel_of(logic [3:0] s);
    case (s)
      4'd0: return 8'b10_00_10_00;
      4'd1: return 8'b00_01_01_00;
      4'd2: return 8'b00_10_01_00;
      4'd4: return 8'b01_00_00_00;
      4'd6: return 8'b00_10_00_10;
      4'd7: return 8'b00_10_01_10;
      4'd9: return 8'b00_10_00_01;
      4'd10: return 8'b00_01_10_00;
      default: return 8'b00_00_00_00;
    endcase
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s step %0d: got %0h want %0h", name, row, act, exp);
    end
  endtask
  task automatic step(vec_t x);
    vec_t e;
    rst = x.rst; opcode = x.op; zero = x.z; mem_ready = x.mr;
    sb.push_back(x);
    @(negedge clk);
    e = sb.pop_front();
    chk("state", 32'(state_dbg), 32'(e.st));
    chk("strobes", 32'({pc_write, adr_src, ir_write, mem_write, reg_write}), 32'(e.stb));
    chk("selects", 32'({result_src, alu_src_a, alu_src_b, ALU_op}), 32'(sel_of(e.st)));
    chk("traps", 32'({illegal_instr, bus_error}), 32'(e.fl));
    chk("retired", 32'(retired), 32'(e.ret));
    row++;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b1; opcode = R; zero = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1; opcode = R; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tbl.push_back(v(1, R, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, R, 0, 1, 0, FS, 0, 0));
    tbl.push_back(v(0, R, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(0, R, 0, 1, 6, 0, 0, 0));
    tbl.push_back(v(0, R, 0, 1, 8, RW, 0, 0));
    tbl.push_back(v(0, LW, 0, 1, 0, FS, 0, 1));
    tbl.push_back(v(0, LW, 0, 1, 1, 0, 0, 1));
    tbl.push_back(v(0, LW, 0, 1, 2, 0, 0, 1));
    tbl.push_back(v(0, LW, 0, 0, 3, ADR, 0, 1));
    tbl.push_back(v(0, LW, 0, 0, 3, ADR, 0, 1));
    tbl.push_back(v(0, LW, 0, 0, 3, ADR, 0, 1));
    tbl.push_back(v(0, LW, 0, 1, 3, ADR, 0, 1));
    tbl.push_back(v(0, LW, 0, 1, 4, RW, 0, 1));
    tbl.push_back(v(0, SW, 0, 1, 0, FS, 0, 2));
    tbl.push_back(v(0, SW, 0, 1, 1, 0, 0, 2));
    tbl.push_back(v(0, SW, 0, 1, 2, 0, 0, 2));
    tbl.push_back(v(0, SW, 0, 0, 5, MW, 0, 2));
    tbl.push_back(v(0, SW, 0, 1, 5, MW, 0, 2));
    tbl.push_back(v(0, BQ, 1, 1, 0, FS, 0, 3));
    tbl.push_back(v(0, BQ, 1, 1, 1, 0, 0, 3));
    tbl.push_back(v(0, BQ, 1, 1, 9, PC, 0, 3));
    tbl.push_back(v(0, BQ, 0, 1, 0, FS, 0, 4));
    tbl.push_back(v(0, BQ, 0, 1, 1, 0, 0, 4));
    tbl.push_back(v(0, BQ, 0, 1, 9, 0, 0, 4));
    tbl.push_back(v(0, JL, 0, 1, 0, FS, 0, 5));
    tbl.push_back(v(0, JL, 0, 1, 1, 0, 0, 5));
    tbl.push_back(v(0, JL, 0, 1, 10, PC, 0, 5));
    tbl.push_back(v(0, JL, 0, 1, 8, RW, 0, 5));
    tbl.push_back(v(0, I, 0, 1, 0, FS, 0, 6));
    tbl.push_back(v(0, I, 0, 1, 1, 0, 0, 6));
    tbl.push_back(v(0, I, 0, 1, 7, 0, 0, 6));
    tbl.push_back(v(0, I, 0, 1, 8, RW, 0, 6));
    tbl.push_back(v(0, BAD, 0, 1, 0, FS, 0, 7));
    tbl.push_back(v(0, BAD, 0, 1, 1, 0, 0, 7));
    tbl.push_back(v(0, BAD, 0, 1, 15, 0, 2'b10, 7));
    tbl.push_back(v(0, BAD, 0, 1, 15, 0, 2'b10, 7));
    tbl.push_back(v(1, R, 0, 1, 15, 0, 2'b10, 7));
    tbl.push_back(v(0, R, 0, 1, 0, FS, 0, 0));
    for (int k = 0; k < tbl.size(); k++) step(tbl[k]);
    do_reset();
    for (int k = 0; k < 14; k++) step(v(0, R, 0, 0, 0, 0, 0, 0));
    step(v(0, R, 0, 1, 0, FS, 0, 0));
    step(v(0, R, 0, 1, 1, 0, 0, 0));
    do_reset();
    for (int k = 0; k < 15; k++) step(v(0, R, 0, 0, 0, 0, 0, 0));
    step(v(0, R, 0, 1, 15, 0, 2'b01, 0));
    step(v(0, R, 0, 1, 15, 0, 2'b01, 0));
    do_reset();
    step(v(0, SW, 0, 1, 0, FS, 0, 0));
    step(v(0, SW, 0, 1, 1, 0, 0, 0));
    step(v(0, SW, 0, 1, 2, 0, 0, 0));
    for (int k = 0; k < 15; k++) step(v(0, SW, 0, 0, 5, k == 14 ? ADR : MW, 0, 0));
    step(v(0, SW, 0, 1, 15, 0, 2'b01, 0));
    do_reset();
    step(v(0, R, 0, 1, 0, FS, 0, 0));
    step(v(0, R, 0, 1, 1, 0, 0, 0));
    step(v(0, R, 0, 1, 6, 0, 0, 0));
    step(v(0, R, 0, 1, 8, RW, 0, 0));
    step(v(0, SW, 0, 1, 0, FS, 0, 1));
    step(v(0, SW, 0, 1, 1, 0, 0, 1));
    step(v(0, SW, 0, 1, 2, 0, 0, 1));
    step(v(0, SW, 0, 0, 5, MW, 0, 1));
    step(v(1, SW, 0, 1, 5, ADR, 0, 1));
    step(v(0, SW, 0, 0, 0, 0, 0, 0));
    step(v(0, SW, 0, 0, 0, 0, 0, 0));
    do_reset();
    for (int k = 0; k < 17; k++) begin
      step(v(0, R, 0, 1, 0, FS, 0, CW'(k)));
      step(v(0, R, 0, 1, 1, 0, 0, CW'(k)));
      step(v(0, R, 0, 1, 6, 0, 0, CW'(k)));
      step(v(0, R, 0, 1, 8, RW, 0, CW'(k)));
    end
    step(v(0, R, 0, 1, 0, FS, 0, CW'(17)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
